// File: rtl/bsr_pkg.sv
// Shared encodings and chain layout helpers for the boundary-scan register.
package bsr_pkg;

  typedef enum logic [1:0] {
    BSR_NORMAL = 2'b00,
    BSR_EXTEST = 2'b01,
    BSR_INTEST = 2'b10,
    BSR_CLAMP  = 2'b11
  } bsr_mode_e;

  // Chain is laid out LSB first: input cells, output cells, control cells.
  function automatic int bsr_in_off();
    return 0;
  endfunction

  function automatic int bsr_out_off(int in_w);
    return in_w;
  endfunction

  function automatic int bsr_oe_off(int in_w, int out_w);
    return in_w + out_w;
  endfunction

  function automatic int bsr_len(int in_w, int out_w, int oe_grp);
    return in_w + out_w + oe_grp;
  endfunction

endpackage

// File: rtl/bsr_oe_expand.sv
// Replicates each output-enable control bit across its group of pads.
module bsr_oe_expand
  import bsr_pkg::*;
#(
  parameter int OUT_W  = 8,
  parameter int OE_GRP = 2
) (
  input  logic [OE_GRP-1:0] grp_oe,
  output logic [OUT_W-1:0]  pad_oe
);

  localparam int GW = OUT_W / OE_GRP;

  // One control cell fans out to a contiguous slice of GW pads.
  for (genvar g = 0; g < OE_GRP; g++) begin : g_grp
    assign pad_oe[g*GW +: GW] = {GW{grp_oe[g]}};
  end

endmodule

// File: rtl/bsr_param_chain.sv
// Parametrised boundary-scan register for one pad ring: capture/shift/update
// chain plus the combinational core/pad muxing selected by the instruction mode.
module bsr_param_chain
  import bsr_pkg::*;
#(
  parameter int IN_W     = 4,
  parameter int OUT_W    = 8,
  parameter int OE_GRP   = 2,
  parameter bit SAFE_OUT = 1'b0,
  parameter bit SAFE_OE  = 1'b0,
  parameter int CNT_W    = 8
) (
  input  logic              clockDR,
  input  logic              reset_bar,
  input  logic [1:0]        mode,
  input  logic              capture_en,
  input  logic              shift_en,
  input  logic              update_en,
  input  logic              scan_in,
  output logic              scan_out,
  input  logic [IN_W-1:0]   pad_in,
  output logic [IN_W-1:0]   core_in,
  input  logic [OUT_W-1:0]  core_out,
  input  logic [OE_GRP-1:0] core_oe,
  output logic [OUT_W-1:0]  pad_out,
  output logic [OUT_W-1:0]  pad_oe,
  output logic [CNT_W-1:0]  shift_cnt,
  output logic              len_err,
  output logic              proto_err
);

  localparam int L       = bsr_len(IN_W, OUT_W, OE_GRP);
  localparam int IN_OFF  = bsr_in_off();
  localparam int OUT_OFF = bsr_out_off(IN_W);
  localparam int OE_OFF  = bsr_oe_off(IN_W, OUT_W);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_LEN = CNT_W'(L);

  logic [L-1:0]      sr;
  logic [IN_W-1:0]   ur_in;
  logic [OUT_W-1:0]  ur_out;
  logic [OE_GRP-1:0] ur_oe;
  logic [OE_GRP-1:0] sel_oe;

  // Shift stage: shift wins over capture when both are requested.
  always_ff @(posedge clockDR or negedge reset_bar) begin
    if (!reset_bar)      sr <= '0;
    else if (shift_en)   sr <= {scan_in, sr[L-1:1]};
    else if (capture_en) sr <= {core_oe, core_out, pad_in};
  end

  // Bits shifted since the last capture; saturates instead of wrapping.
  always_ff @(posedge clockDR or negedge reset_bar) begin
    if (!reset_bar)                            shift_cnt <= '0;
    else if (shift_en && shift_cnt != CNT_MAX) shift_cnt <= shift_cnt + 1'b1;
    else if (!shift_en && capture_en)          shift_cnt <= '0;
  end

  // Update stage samples the pre-edge shift register, even while shifting.
  always_ff @(posedge clockDR or negedge reset_bar) begin
    if (!reset_bar) begin
      ur_in  <= '0;
      ur_out <= {OUT_W{SAFE_OUT}};
      ur_oe  <= {OE_GRP{SAFE_OE}};
    end else if (update_en) begin
      ur_in  <= sr[IN_OFF  +: IN_W];
      ur_out <= sr[OUT_OFF +: OUT_W];
      ur_oe  <= sr[OE_OFF  +: OE_GRP];
    end
  end

  // Sticky protocol flags, cleared only by reset.
  always_ff @(posedge clockDR or negedge reset_bar) begin
    if (!reset_bar) begin
      len_err   <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      if (update_en && shift_cnt != CNT_LEN) len_err   <= 1'b1;
      if (capture_en && shift_en)            proto_err <= 1'b1;
    end
  end

  assign scan_out = sr[0];

  // Mode mux is purely combinational so a mode change hits the pads at once.
  always_comb begin
    core_in = pad_in;
    pad_out = ur_out;
    sel_oe  = ur_oe;
    case (mode)
      BSR_EXTEST: ;
      BSR_INTEST: core_in = ur_in;
      BSR_CLAMP:  ;
      default: begin
        pad_out = core_out;
        sel_oe  = core_oe;
      end
    endcase
  end

  bsr_oe_expand #(.OUT_W(OUT_W), .OE_GRP(OE_GRP)) u_oe_expand (
    .grp_oe (sel_oe),
    .pad_oe (pad_oe)
  );

endmodule

// File: tb/tb_bsr_param_chain.sv
// Directed bench for bsr_param_chain with a bit-level reference model
// checked every cycle, plus hand-computed literal expectations.
module tb_bsr_param_chain;

  localparam int IN_W   = 4;
  localparam int OUT_W  = 8;
  localparam int OE_GRP = 2;
  localparam int CNT_W  = 8;
  localparam int L      = IN_W + OUT_W + OE_GRP;
  localparam int GW     = OUT_W / OE_GRP;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic              clockDR = 1'b0;
  logic              reset_bar = 1'b0;
  logic [1:0]        mode = 2'b01;
  logic              capture_en = 1'b0, shift_en = 1'b0, update_en = 1'b0, scan_in = 1'b0;
  logic              scan_out;
  logic [IN_W-1:0]   pad_in = '0;
  logic [IN_W-1:0]   core_in;
  logic [OUT_W-1:0]  core_out = '0;
  logic [OE_GRP-1:0] core_oe = '0;
  logic [OUT_W-1:0]  pad_out, pad_oe;
  logic [CNT_W-1:0]  shift_cnt;
  logic              len_err, proto_err;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  bsr_param_chain #(
    .IN_W(IN_W), .OUT_W(OUT_W), .OE_GRP(OE_GRP),
    .SAFE_OUT(1'b0), .SAFE_OE(1'b0), .CNT_W(CNT_W)
  ) dut (
    .clockDR(clockDR), .reset_bar(reset_bar), .mode(mode),
    .capture_en(capture_en), .shift_en(shift_en), .update_en(update_en),
    .scan_in(scan_in), .scan_out(scan_out), .pad_in(pad_in), .core_in(core_in),
    .core_out(core_out), .core_oe(core_oe), .pad_out(pad_out), .pad_oe(pad_oe),
    .shift_cnt(shift_cnt), .len_err(len_err), .proto_err(proto_err)
  );

  always #5 clockDR = ~clockDR;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", name, got, exp, $time);
    end
  endtask

  // Reference model: chain as a flat bit array, index 0 nearest scan_out.
  bit m_sr[L];
  bit m_ur[L];
  bit m_old[L];
  int m_cnt;
  bit m_len, m_pro;

  always @(posedge clockDR or negedge reset_bar) begin
    if (!reset_bar) begin
      for (int i = 0; i < L; i++) begin m_sr[i] = 1'b0; m_ur[i] = 1'b0; end
      m_cnt = 0; m_len = 1'b0; m_pro = 1'b0;
    end else begin
      m_old = m_sr;
      if (update_en) begin
        m_ur = m_old;
        if (m_cnt != L) m_len = 1'b1;
      end
      if (capture_en && shift_en) m_pro = 1'b1;
      if (shift_en) begin
        for (int i = 0; i < L - 1; i++) m_sr[i] = m_old[i+1];
        m_sr[L-1] = scan_in;
        if (m_cnt < CMAX) m_cnt = m_cnt + 1;
      end else if (capture_en) begin
        for (int i = 0; i < L; i++) begin
          if (i < IN_W)              m_sr[i] = pad_in[i];
          else if (i < IN_W + OUT_W) m_sr[i] = core_out[i-IN_W];
          else                       m_sr[i] = core_oe[i-IN_W-OUT_W];
        end
        m_cnt = 0;
      end
    end
  end

  // Per-cycle compare of every output against the model.
  always @(negedge clockDR) begin
    if (chk_en) begin
      logic [IN_W-1:0]  e_ci;
      logic [OUT_W-1:0] e_po, e_oe;
      for (int i = 0; i < IN_W; i++)
        e_ci[i] = (mode == 2'b10) ? m_ur[i] : pad_in[i];
      for (int i = 0; i < OUT_W; i++) begin
        e_po[i] = (mode == 2'b00) ? core_out[i] : m_ur[IN_W+i];
        e_oe[i] = (mode == 2'b00) ? core_oe[i/GW] : m_ur[IN_W+OUT_W+i/GW];
      end
      check("m_scan_out", 32'(scan_out), 32'(m_sr[0]));
      check("m_core_in", 32'(core_in), 32'(e_ci));
      check("m_pad_out", 32'(pad_out), 32'(e_po));
      check("m_pad_oe", 32'(pad_oe), 32'(e_oe));
      check("m_shift_cnt", 32'(shift_cnt), 32'(m_cnt));
      check("m_len_err", 32'(len_err), 32'(m_len));
      check("m_proto_err", 32'(proto_err), 32'(m_pro));
    end
  end

  // One clock: inputs set now are sampled at the next rising edge.
  task automatic step();
    @(negedge clockDR); #1;
  endtask

  task automatic capture();
    capture_en = 1'b1; step(); capture_en = 1'b0;
  endtask

  task automatic shift_word(input logic [L-1:0] w, input int n);
    shift_en = 1'b1;
    for (int i = 0; i < n; i++) begin scan_in = w[i]; step(); end
    shift_en = 1'b0; scan_in = 1'b0;
  endtask

  task automatic update();
    update_en = 1'b1; step(); update_en = 1'b0;
  endtask

  logic [L-1:0] stream;

  initial begin
    #12; reset_bar = 1'b1;
    step();
    chk_en = 1'b1;

    // 1: reset state in EXTEST
    check("rst_pad_oe", 32'(pad_oe), 32'h0);
    check("rst_pad_out", 32'(pad_out), 32'h0);
    check("rst_scan_out", 32'(scan_out), 32'h0);
    check("rst_shift_cnt", 32'(shift_cnt), 32'h0);

    // 2: capture then unload the whole chain
    pad_in = 4'hA; core_out = 8'h5C; core_oe = 2'b10;
    capture();
    shift_en = 1'b1;
    for (int i = 0; i < L; i++) begin stream[i] = scan_out; step(); end
    shift_en = 1'b0;
    check("unload_stream", 32'(stream), 32'h25CA);
    check("unload_cnt", 32'(shift_cnt), 32'd14);

    // 3: preload a pattern, update, observe on pads and core
    capture();
    shift_word({2'b11, 8'hF0, 4'h3}, L);
    update();
    mode = 2'b01; #1;
    check("ext_pad_out", 32'(pad_out), 32'hF0);
    check("ext_pad_oe", 32'(pad_oe), 32'hFF);
    check("ext_len_err", 32'(len_err), 32'h0);
    mode = 2'b10; #1;
    check("int_core_in", 32'(core_in), 32'h3);
    mode = 2'b00; #1;
    check("norm_pad_out", 32'(pad_out), 32'h5C);
    check("norm_pad_oe", 32'(pad_oe), 32'hF0);

    // 4: short shift sets len_err, which then sticks
    capture();
    shift_word(14'h1555, L - 1);
    update();
    check("short_len_err", 32'(len_err), 32'h1);
    capture();
    shift_word(14'h2AAA, L);
    update();
    check("sticky_len_err", 32'(len_err), 32'h1);

    // 5: capture+shift together shifts; update while shifting takes old sr
    pad_in = 4'h0; core_out = 8'h00; core_oe = 2'b00;
    capture();
    pad_in = 4'hF; core_out = 8'hFF; core_oe = 2'b11;
    capture_en = 1'b1; shift_en = 1'b1; scan_in = 1'b1; step();
    capture_en = 1'b0; scan_in = 1'b0;
    check("proto_err", 32'(proto_err), 32'h1);
    check("proto_scan_out", 32'(scan_out), 32'h0);
    update_en = 1'b1; step(); update_en = 1'b0; shift_en = 1'b0;
    mode = 2'b01; #1;
    check("upd_shift_pad_oe", 32'(pad_oe), 32'hF0);
    check("upd_shift_pad_out", 32'(pad_out), 32'h00);
    check("upd_shift_cnt", 32'(shift_cnt), 32'd2);

    // counter saturation
    shift_word('0, CMAX + 5);
    check("cnt_sat", 32'(shift_cnt), 32'(CMAX));

    // 6: reset mid-shift while clamped drives safe values at once
    capture();
    shift_word('1, L);
    update();
    mode = 2'b11; #1;
    check("clamp_pad_out", 32'(pad_out), 32'hFF);
    shift_word(14'h3F, 6);
    reset_bar = 1'b0; #1;
    check("rst_mid_pad_out", 32'(pad_out), 32'h0);
    check("rst_mid_pad_oe", 32'(pad_oe), 32'h0);
    check("rst_mid_cnt", 32'(shift_cnt), 32'h0);
    check("rst_mid_len", 32'(len_err), 32'h0);
    check("rst_mid_proto", 32'(proto_err), 32'h0);
    check("rst_mid_scan", 32'(scan_out), 32'h0);
    step();
    reset_bar = 1'b1;
    step(); step();

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
